// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage register with flush and optional 2-entry skid buffer
module pipe_stage_elastic #(
  parameter int                DATA_W      = 96,
  parameter int                CTRL_W      = 10,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                SKID        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam bit HAS_SKID = (SKID != 0);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] m_data_q;
  logic [CTRL_W-1:0] m_ctrl_q;
  logic [DATA_W-1:0] s_data_q;
  logic [CTRL_W-1:0] s_ctrl_q;
  logic              in_xfer;
  logic              out_xfer;
  logic              load_m_in;
  logic              load_m_skid;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) state_d = ST_FULL;
        end
        ST_FULL: begin
          if (in_xfer && !out_xfer && HAS_SKID) state_d = ST_SKID;
          else if (!in_xfer && out_xfer)        state_d = ST_EMPTY;
        end
        ST_SKID: begin
          if (out_xfer) state_d = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    case (state_q)
      ST_FULL: occupancy = 2'd1;
      ST_SKID: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
    // a bubble must never present live write enables downstream
    out_ctrl  = out_valid ? m_ctrl_q : CTRL_BUBBLE;
    out_data  = m_data_q;
  end

  // without a skid entry, FULL can only accept when it also drains
  assign load_m_in   = in_xfer & ((state_q == ST_EMPTY) | ((state_q == ST_FULL) & out_xfer));
  assign load_m_skid = (state_q == ST_SKID) & out_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q <= '0;
      m_ctrl_q <= CTRL_BUBBLE;
    end else if (flush) begin
      m_data_q <= '0;
      m_ctrl_q <= CTRL_BUBBLE;
    end else if (load_m_in) begin
      m_data_q <= in_data;
      m_ctrl_q <= in_ctrl;
    end else if (load_m_skid) begin
      m_data_q <= s_data_q;
      m_ctrl_q <= s_ctrl_q;
    end
  end

  generate
    if (HAS_SKID) begin : g_skid
      logic in_ready_q;
      logic load_s;

      assign load_s = in_xfer & (state_q == ST_FULL) & ~out_xfer;

      // ready is taken from the next state so it never sees out_ready combinationally
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          in_ready_q <= 1'b1;
          s_data_q   <= '0;
          s_ctrl_q   <= '0;
        end else begin
          in_ready_q <= (state_d != ST_SKID);
          if (flush) begin
            s_data_q <= '0;
            s_ctrl_q <= '0;
          end else if (load_s) begin
            s_data_q <= in_data;
            s_ctrl_q <= in_ctrl;
          end
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign s_data_q = '0;
      assign s_ctrl_q = CTRL_BUBBLE;
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - queue-model bench for both skid and single-register builds
module tb_pipe_stage_elastic;

  localparam int             DW    = 96;
  localparam int             CW    = 10;
  localparam logic [CW-1:0]  BUB_B = 10'h155;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [CW-1:0] a_out_ctrl;
  logic [1:0]    a_occ;
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [CW-1:0] b_out_ctrl;
  logic [1:0]    b_occ;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit log_en = 1'b0;

  logic [DW+CW-1:0] qa[$];
  logic [DW+CW-1:0] qb[$];
  bit               clr_a = 1'b1;
  bit               clr_b = 1'b1;
  bit               m_ia, m_oa, m_ib, m_ob;
  logic [DW-1:0]    seen[$];

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(10'h000), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .occupancy(a_occ)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB_B), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .occupancy(b_occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit orr, input bit fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = d[CW-1:0] ^ 10'h2a5;
    out_ready = orr;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // FIFO view: skid build holds up to 2, single build up to 1 and accepts while draining
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      qa.delete(); qb.delete();
      clr_a = 1'b1; clr_b = 1'b1;
    end else begin
      m_ia = in_valid && (qa.size() < 2);
      m_oa = (qa.size() > 0) && out_ready;
      m_ib = in_valid && (out_ready || qb.size() == 0);
      m_ob = (qb.size() > 0) && out_ready;
      if (flush) begin
        qa.delete(); qb.delete();
        clr_a = 1'b1; clr_b = 1'b1;
      end else begin
        if (m_oa) void'(qa.pop_front());
        if (m_ia) begin qa.push_back({in_ctrl, in_data}); clr_a = 1'b0; end
        if (m_ob) void'(qb.pop_front());
        if (m_ib) begin qb.push_back({in_ctrl, in_data}); clr_b = 1'b0; end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      chk("a_valid", a_out_valid, qa.size() > 0);
      chk("a_occ", a_occ, qa.size());
      chk("a_in_ready", a_in_ready, qa.size() < 2);
      if (qa.size() > 0) begin
        chk("a_data", a_out_data, qa[0][DW-1:0]);
        chk("a_ctrl", a_out_ctrl, qa[0][DW+CW-1:DW]);
      end else begin
        chk("a_ctrl_bubble", a_out_ctrl, 10'h000);
        if (clr_a) chk("a_data_clr", a_out_data, 0);
      end
      chk("b_valid", b_out_valid, qb.size() > 0);
      chk("b_occ", b_occ, qb.size());
      chk("b_in_ready", b_in_ready, out_ready || qb.size() == 0);
      if (qb.size() > 0) begin
        chk("b_data", b_out_data, qb[0][DW-1:0]);
        chk("b_ctrl", b_out_ctrl, qb[0][DW+CW-1:DW]);
      end else begin
        chk("b_ctrl_bubble", b_out_ctrl, BUB_B);
        if (clr_b) chk("b_data_clr", b_out_data, 0);
      end
      if (log_en && a_out_valid && out_ready) seen.push_back(a_out_data);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_ctrl", a_out_ctrl, 10'h000);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_ctrl", b_out_ctrl, BUB_B);
    rst = 1'b0;
    chk_en = 1'b1;
    log_en = 1'b1;

    // streaming 1..8
    drive(1'b1, 96'h1, 1'b1, 1'b0);
    chk("lat_valid", a_out_valid, 1);
    chk("lat_data", a_out_data, 96'h1);
    for (int i = 2; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      chk("stream_in_ready", a_in_ready, 1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("stream_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("stream_order", seen[i], DW'(i + 1));

    // back-pressure A,B,C with a 3-cycle stall
    seen.delete();
    drive(1'b1, 96'hA, 1'b1, 1'b0);
    chk("bp_occ1", a_occ, 1);
    drive(1'b1, 96'hB, 1'b0, 1'b0);
    chk("bp_occ2", a_occ, 2);
    chk("bp_ready0", a_in_ready, 0);
    drive(1'b1, 96'hC, 1'b0, 1'b0);
    drive(1'b1, 96'hC, 1'b0, 1'b0);
    chk("bp_hold_data", a_out_data, 96'hA);
    chk("bp_hold_occ", a_occ, 2);
    drive(1'b1, 96'hC, 1'b1, 1'b0);
    drive(1'b1, 96'hC, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("bp_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("bp_first", seen[0], 96'hA);
      chk("bp_second", seen[1], 96'hB);
      chk("bp_third", seen[2], 96'hC);
    end

    // single-register build: combinational ready and in-place reload
    drive(1'b1, 96'h21, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 96'h22; in_ctrl = 10'h22 ^ 10'h2a5; out_ready = 1'b0;
    #1;
    chk("b_ready_low", b_in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("b_ready_follow", b_in_ready, 1);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("b_stall_data", b_out_data, 96'h21);
    chk("b_stall_occ", b_occ, 1);
    drive(1'b1, 96'h23, 1'b1, 1'b0);
    chk("b_reload_data", b_out_data, 96'h23);
    chk("b_reload_occ", b_occ, 1);
    chk("a_skid_to_main", a_out_data, 96'h22);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // flush with occupancy 2 and a simultaneous input
    seen.delete();
    drive(1'b1, 96'h31, 1'b0, 1'b0);
    drive(1'b1, 96'h32, 1'b0, 1'b0);
    chk("fl_pre_occ", a_occ, 2);
    drive(1'b1, 96'hF, 1'b1, 1'b1);
    chk("fl_a_valid", a_out_valid, 0);
    chk("fl_a_occ", a_occ, 0);
    chk("fl_a_ctrl", a_out_ctrl, 10'h000);
    chk("fl_a_data", a_out_data, 0);
    chk("fl_a_ready", a_in_ready, 1);
    chk("fl_b_occ", b_occ, 0);
    chk("fl_b_ctrl", b_out_ctrl, BUB_B);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("fl_count", seen.size(), 1);
    if (seen.size() == 1) chk("fl_drained", seen[0], 96'h31);

    // asynchronous reset with occupancy 2
    drive(1'b1, 96'h41, 1'b0, 1'b0);
    drive(1'b1, 96'h42, 1'b0, 1'b0);
    chk("rs_pre_occ", a_occ, 2);
    rst = 1'b1;
    #1;
    chk("rs_a_valid", a_out_valid, 0);
    chk("rs_a_occ", a_occ, 0);
    chk("rs_a_ready", a_in_ready, 1);
    chk("rs_a_ctrl", a_out_ctrl, 10'h000);
    chk("rs_b_valid", b_out_valid, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // random traffic against the queue model
    log_en = 1'b0;
    repeat (10000) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
